sdram_model: RTL

Synthesizable single-chip SDR SDRAM responder (x16). It decodes the command bus driven by `sdram_ctrl`, holds a small aliased storage array, and returns read bursts with programmed CAS latency and DQM masking. Sticky protocol-violation flags make it usable as the memory end of controller benches and FPGA loopback tests.

---
 rtl/sdram_model.sv | 326 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_model.sv
`default_nettype none
// ============================================================================
// Module   : sdram_model
// Purpose  : Synthesizable x16 SDR SDRAM responder. Decodes the command bus,
//            keeps per-bank open-row state and timing counters, stores data
//            in a small aliased array, returns CAS-latency read bursts with
//            DQM masking and raises sticky protocol-violation flags.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_model #(
    parameter int ROW_WIDTH     = 13,
    parameter int COL_WIDTH     = 9,
    parameter int BA_WIDTH      = 2,
    parameter int MEM_ADR_WIDTH = 12,
    parameter int tRCD          = 3,
    parameter int tRP           = 2,
    parameter int tRC           = 7,
    parameter int tMRD          = 2
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst,
    input  logic                cke_i,
    input  logic                cs_n_i,
    input  logic                ras_i,
    input  logic                cas_i,
    input  logic                we_i,
    input  logic [BA_WIDTH-1:0] ba_i,
    input  logic [12:0]         a_i,
    input  logic [15:0]         dq_i,
    input  logic [1:0]          dqm_i,
    output logic [15:0]         dq_o,
    output logic                dq_oe_o,
    output logic [7:0]          err_o
);

    localparam int NB        = 1 << BA_WIDTH;
    localparam int BR_W      = BA_WIDTH + ROW_WIDTH;
    localparam int MEM_DEPTH = 1 << MEM_ADR_WIDTH;
    localparam int T_MAX_A   = (tRCD > tRP) ? tRCD : tRP;
    localparam int T_MAX_B   = (tRC > tMRD) ? tRC : tMRD;
    localparam int T_MAX     = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CNT_W     = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_RCD     = CNT_W'(tRCD);
    localparam logic [CNT_W-1:0] C_RP      = CNT_W'(tRP);
    localparam logic [CNT_W-1:0] C_RC      = CNT_W'(tRC);
    localparam logic [CNT_W-1:0] C_MRD     = CNT_W'(tMRD);

    // {ras, cas, we} encodings
    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_BST = 3'b110;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;

    // Burst engine states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    // Saturating edge counter
    function automatic logic [CNT_W-1:0] f_sat(input logic [CNT_W-1:0] v);
        return (v == C_CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Next column inside a burst-length-aligned block (m = BL-1)
    function automatic logic [COL_WIDTH-1:0] f_next(input logic [COL_WIDTH-1:0] c,
                                                    input logic [COL_WIDTH-1:0] m);
        return (c & ~m) | ((c + 1'b1) & m);
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [2:0]           w_cmd;
    logic                 w_bst, w_rd, w_wr, w_act, w_pre, w_ref, w_mrs, w_any, w_rw;
    logic                 w_a10, w_cl_bad, w_one_word, w_term;
    logic [COL_WIDTH-1:0] w_col, w_mask_dec;
    logic [ROW_WIDTH-1:0] w_row;

    logic [COL_WIDTH-1:0] mode_mask_q;
    logic                 cl3_q, single_q, mrs_seen_q;

    logic [NB-1:0]                act_q;
    logic [NB-1:0][ROW_WIDTH-1:0] row_q;
    logic [NB-1:0][CNT_W-1:0]     rcd_q, rp_q, rc_q;
    logic [CNT_W-1:0]             ref_q, mrd_q;

    logic [1:0]           state_q, state_d;
    logic [BR_W-1:0]      bst_br_q, bst_br_d;
    logic [COL_WIDTH-1:0] bst_col_q, bst_col_d, bst_rem_q, bst_rem_d, bst_mask_q, bst_mask_d;
    logic                 bst_ap_q, bst_ap_d;

    logic                     w_iss_rd, w_iss_wr, w_close;
    logic [BA_WIDTH-1:0]      w_close_ba;
    logic [MEM_ADR_WIDTH-1:0] w_iss_adr;

    logic [15:0] mem_q [MEM_DEPTH];

    logic                     p1_v_q, p2_v_q, dqm_q;
    logic [MEM_ADR_WIDTH-1:0] p1_a_q, p2_a_q;
    logic                     w_src_v;
    logic [MEM_ADR_WIDTH-1:0] w_src_a;
    logic [15:0]              dq_q;
    logic                     oe_q;
    logic [7:0]               err_q, w_err_set;

    // ------------------------------------------------------------------
    // Command decode: anything unselected or clock-disabled is a NOP
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd      = (cke_i && !cs_n_i) ? {ras_i, cas_i, we_i} : C_NOP;
        w_bst      = (w_cmd == C_BST);
        w_rd       = (w_cmd == C_RD);
        w_wr       = (w_cmd == C_WR);
        w_act      = (w_cmd == C_ACT);
        w_pre      = (w_cmd == C_PRE);
        w_ref      = (w_cmd == C_REF);
        w_mrs      = (w_cmd == C_MRS);
        w_any      = (w_cmd != C_NOP);
        w_rw       = w_rd || w_wr;
        w_a10      = a_i[10];
        w_col      = a_i[COL_WIDTH-1:0];
        w_row      = a_i[ROW_WIDTH-1:0];
        w_cl_bad   = (a_i[6:4] != 3'd2) && (a_i[6:4] != 3'd3);
        w_one_word = (mode_mask_q == '0) || (w_wr && single_q);
        w_term     = w_bst || w_rw ||
                     (w_pre && (w_a10 || (ba_i == bst_br_q[BR_W-1 -: BA_WIDTH])));
        case (a_i[2:0])
            3'b001:  w_mask_dec = COL_WIDTH'(1);
            3'b010:  w_mask_dec = COL_WIDTH'(3);
            3'b011:  w_mask_dec = COL_WIDTH'(7);
            3'b111:  w_mask_dec = '1;
            default: w_mask_dec = '0;
        endcase
    end

    // Violation detection for the command on this edge
    always_comb begin
        w_err_set    = '0;
        w_err_set[0] = w_rw && (rcd_q[ba_i] < C_RCD);
        w_err_set[1] = w_act && (rp_q[ba_i] < C_RP);
        w_err_set[2] = (w_act && (rc_q[ba_i] < C_RC)) || (w_any && (ref_q < C_RC));
        w_err_set[3] = (w_any && (mrd_q < C_MRD)) || (w_mrs && w_cl_bad);
        w_err_set[4] = (w_rw && !act_q[ba_i]) || (w_act && act_q[ba_i]);
        w_err_set[5] = w_ref && (act_q != '0);
        w_err_set[6] = w_rw && !mrs_seen_q;
        w_err_set[7] = w_wr && w_src_v;
    end

    // Mode register, global REF/MRS spacing counters and sticky error flags
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            mode_mask_q <= '0;
            cl3_q       <= 1'b0;
            single_q    <= 1'b0;
            mrs_seen_q  <= 1'b0;
            ref_q       <= C_CNT_MAX;
            mrd_q       <= C_CNT_MAX;
            err_q       <= '0;
        end else begin
            err_q <= err_q | w_err_set;
            ref_q <= w_ref ? C_CNT_ONE : f_sat(ref_q);
            mrd_q <= w_mrs ? C_CNT_ONE : f_sat(mrd_q);
            if (w_mrs) begin
                mode_mask_q <= w_mask_dec;
                cl3_q       <= (a_i[6:4] == 3'd3);
                single_q    <= a_i[9];
                mrs_seen_q  <= 1'b1;
            end
        end
    end

    // Per-bank open/closed state, open row and spacing counters
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            act_q <= '0;
            rcd_q <= {NB{C_CNT_MAX}};
            rp_q  <= {NB{C_CNT_MAX}};
            rc_q  <= {NB{C_CNT_MAX}};
        end else begin
            for (int b = 0; b < NB; b++) begin
                rcd_q[b] <= f_sat(rcd_q[b]);
                rp_q[b]  <= f_sat(rp_q[b]);
                rc_q[b]  <= f_sat(rc_q[b]);
                if ((w_pre && (w_a10 || (ba_i == BA_WIDTH'(b)))) ||
                    (w_close && (w_close_ba == BA_WIDTH'(b)))) begin
                    act_q[b] <= 1'b0;
                    rp_q[b]  <= C_CNT_ONE;
                end
                if (w_act && (ba_i == BA_WIDTH'(b))) begin
                    act_q[b] <= 1'b1;
                    row_q[b] <= w_row;
                    rcd_q[b] <= C_CNT_ONE;
                    rc_q[b]  <= C_CNT_ONE;
                end
            end
        end
    end

    // Burst engine state register
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Burst engine next state: a new access restarts, termination or last word idles
    always_comb begin
        state_d = state_q;
        if (w_rw) begin
            state_d = w_one_word ? S_IDLE : (w_rd ? S_RD : S_WR);
        end else if ((state_q != S_IDLE) && (w_term || (bst_rem_q == COL_WIDTH'(1)))) begin
            state_d = S_IDLE;
        end
    end

    // Burst engine outputs: word issue, address and auto-precharge close
    always_comb begin
        w_iss_rd   = 1'b0;
        w_iss_wr   = 1'b0;
        w_iss_adr  = '0;
        w_close    = 1'b0;
        w_close_ba = ba_i;
        bst_br_d   = bst_br_q;
        bst_col_d  = bst_col_q;
        bst_rem_d  = bst_rem_q;
        bst_mask_d = bst_mask_q;
        bst_ap_d   = bst_ap_q;
        if (w_rw) begin
            w_iss_rd   = w_rd;
            w_iss_wr   = w_wr;
            w_iss_adr  = MEM_ADR_WIDTH'({ba_i, row_q[ba_i], w_col});
            bst_br_d   = {ba_i, row_q[ba_i]};
            bst_col_d  = f_next(w_col, mode_mask_q);
            bst_rem_d  = mode_mask_q;
            bst_mask_d = mode_mask_q;
            bst_ap_d   = w_a10;
            // A one-word access is its own last word
            if (w_one_word && w_a10) begin
                w_close = 1'b1;
            end
        end else if ((state_q != S_IDLE) && !w_term) begin
            w_iss_rd  = (state_q == S_RD);
            w_iss_wr  = (state_q == S_WR);
            w_iss_adr = MEM_ADR_WIDTH'({bst_br_q, bst_col_q});
            bst_col_d = f_next(bst_col_q, bst_mask_q);
            bst_rem_d = bst_rem_q - 1'b1;
            if ((bst_rem_q == COL_WIDTH'(1)) && bst_ap_q) begin
                w_close    = 1'b1;
                w_close_ba = bst_br_q[BR_W-1 -: BA_WIDTH];
            end
        end
    end

    // Burst datapath registers
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            bst_br_q   <= '0;
            bst_col_q  <= '0;
            bst_rem_q  <= '0;
            bst_mask_q <= '0;
            bst_ap_q   <= 1'b0;
        end else begin
            bst_br_q   <= bst_br_d;
            bst_col_q  <= bst_col_d;
            bst_rem_q  <= bst_rem_d;
            bst_mask_q <= bst_mask_d;
            bst_ap_q   <= bst_ap_d;
        end
    end

    // Storage write with per-byte masks; contents survive reset
    always_ff @(posedge sdram_clk) begin
        if (!sdram_rst && w_iss_wr) begin
            if (!dqm_i[0]) mem_q[w_iss_adr][7:0]  <= dq_i[7:0];
            if (!dqm_i[1]) mem_q[w_iss_adr][15:8] <= dq_i[15:8];
        end
    end

    // Output stage taps the pipeline at CL-1 stages after issue
    always_comb begin
        w_src_v = cl3_q ? p2_v_q : p1_v_q;
        w_src_a = cl3_q ? p2_a_q : p1_a_q;
    end

    // Read pipeline and registered output; a WRITE flushes pending words
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            p1_v_q <= 1'b0;
            p2_v_q <= 1'b0;
            p1_a_q <= '0;
            p2_a_q <= '0;
            dqm_q  <= 1'b0;
            dq_q   <= '0;
            oe_q   <= 1'b0;
        end else begin
            dqm_q <= |dqm_i;
            if (w_wr) begin
                p1_v_q <= 1'b0;
                p2_v_q <= 1'b0;
                oe_q   <= 1'b0;
            end else begin
                p1_v_q <= w_iss_rd;
                p1_a_q <= w_iss_adr;
                p2_v_q <= p1_v_q;
                p2_a_q <= p1_a_q;
                // dqm_q is the mask from two edges before this word's output edge
                oe_q   <= w_src_v && !dqm_q;
                if (w_src_v && !dqm_q) begin
                    dq_q <= mem_q[w_src_a];
                end
            end
        end
    end

    assign dq_o    = dq_q;
    assign dq_oe_o = oe_q;
    assign err_o   = err_q;

endmodule
`default_nettype wire
